axis_packet_capture: RTL and testbench

- AXI-Stream sink for the network test benches. It terminates the packet stream produced by the replay source, or by the DUT under test.
- For every packet received it measures length in bytes, records an arrival timestamp in clock cycles, and checks strobe legality.
- It pushes one metadata record per packet into a small FIFO, which the bench scoreboard drains through a valid/ready interface.
- A pause input lets the bench apply backpressure.

---
 rtl/axis_packet_capture_if.sv | 29 ++
 rtl/axis_packet_capture.sv | 149 ++++++++++++++
 tb/tb_axis_packet_capture.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_packet_capture_if.sv
// Signal bundle between an AXI-Stream packet source and axis_packet_capture:
// the incoming beat stream plus the per-packet metadata record output.
interface axis_packet_capture_if #(
    parameter int AXIS_WIDTH = 512
);
    logic [AXIS_WIDTH-1:0]   s_data;
    logic [AXIS_WIDTH/8-1:0] s_strb;
    logic                    s_valid;
    logic                    s_eop;
    logic                    s_ready;

    logic [15:0]             m_len;
    logic [63:0]             m_ts;
    logic [15:0]             m_idx;
    logic                    m_err;
    logic                    m_valid;
    logic                    m_ready;

    // The capture block is the slave; the stream source / scoreboard side is the master.
    modport slave (
        input  s_data, s_strb, s_valid, s_eop, m_ready,
        output s_ready, m_len, m_ts, m_idx, m_err, m_valid
    );

    modport master (
        output s_data, s_strb, s_valid, s_eop, m_ready,
        input  s_ready, m_len, m_ts, m_idx, m_err, m_valid
    );
endinterface

// File: rtl/axis_packet_capture.sv
// AXI-Stream packet sink: measures per-packet byte length, arrival cycle and strobe
// legality, and queues one metadata record per packet in a first-word-fall-through FIFO.
module axis_packet_capture #(
    parameter int AXIS_WIDTH    = 512,
    parameter int META_DEPTH    = 4,
    parameter int MAX_PKT_BYTES = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pause,
    axis_packet_capture_if.slave bus,
    output logic [15:0]          pktcount,
    output logic [31:0]          bytecount
);
    localparam int STRB_W = AXIS_WIDTH / 8;
    localparam int PC_W   = $clog2(STRB_W + 1);
    localparam int PTR_W  = $clog2(META_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [16:0] LEN_MAX = 17'(MAX_PKT_BYTES);
    localparam logic [16:0] LEN_CAP = 17'(MAX_PKT_BYTES + 1);

    typedef enum logic {S_IDLE, S_IN_PKT} state_e;

    typedef struct packed {
        logic [15:0] len;
        logic [63:0] ts;
        logic [15:0] idx;
        logic        err;
    } rec_t;

    state_e           state_q, state_d;
    logic [16:0]      len_q, len_d;
    logic [63:0]      ts_q, ts_d;
    logic             err_q, err_d;
    logic [63:0]      counter_q, counter_d;
    logic [15:0]      pktcount_q, pktcount_d;
    logic [31:0]      bytecount_q, bytecount_d;
    logic             s_ready_q, s_ready_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    rec_t             mem_q [META_DEPTH];
    rec_t             rec_d, head;

    logic             accept, push, pop, first, beat_err, data_unused;
    logic [PC_W-1:0]  beat_bytes;
    logic [17:0]      len_sum;
    logic [16:0]      len_acc;

    function automatic logic [PC_W-1:0] popcount(input logic [STRB_W-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < STRB_W; i++) n = n + PC_W'(v[i]);
        return n;
    endfunction

    assign data_unused = ^bus.s_data;
    assign accept      = bus.s_valid & s_ready_q;
    assign pop         = (count_q != '0) & bus.m_ready;
    assign first       = (state_q == S_IDLE);
    assign beat_bytes  = popcount(bus.s_strb);
    // Legal strobes are a non-empty run of ones from bit 0, and full on non-final beats.
    assign beat_err = (bus.s_strb == '0)
                   || ((bus.s_strb & (bus.s_strb + STRB_W'(1))) != '0)
                   || (!bus.s_eop && (bus.s_strb != '1));

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ts_d    = ts_q;
        err_d   = err_q;
        push    = 1'b0;

        // The running length saturates one past the limit so it can never wrap.
        len_sum   = 18'(first ? 17'd0 : len_q) + 18'(beat_bytes);
        len_acc   = (len_sum > 18'(LEN_CAP)) ? LEN_CAP : len_sum[16:0];
        rec_d.len = (len_acc > LEN_MAX) ? LEN_MAX[15:0] : len_acc[15:0];
        rec_d.ts  = first ? counter_q : ts_q;
        rec_d.idx = pktcount_q;
        rec_d.err = (!first && err_q) || beat_err || (len_acc > LEN_MAX);

        if (accept) begin
            len_d = len_acc;
            ts_d  = rec_d.ts;
            err_d = rec_d.err;
            if (bus.s_eop) begin
                push    = 1'b1;
                state_d = S_IDLE;
            end else begin
                state_d = S_IN_PKT;
            end
        end
    end

    always_comb begin
        counter_d   = counter_q + 64'd1;
        pktcount_d  = pktcount_q + 16'(push);
        bytecount_d = bytecount_q + (accept ? 32'(beat_bytes) : 32'd0);
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        // Ready is judged on next cycle's occupancy, so an accepted eop always finds room.
        s_ready_d   = !pause && (count_d < CNT_W'(META_DEPTH));
    end

    // NOTE: flops update with non-blocking '<=' so each one samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            ts_q        <= '0;
            err_q       <= 1'b0;
            counter_q   <= '0;
            pktcount_q  <= '0;
            bytecount_q <= '0;
            s_ready_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            ts_q        <= ts_d;
            err_q       <= err_d;
            counter_q   <= counter_d;
            pktcount_q  <= pktcount_d;
            bytecount_q <= bytecount_d;
            s_ready_q   <= s_ready_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: record storage has no reset; outputs are masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rec_d;
    end

    assign head        = mem_q[rd_ptr_q];
    assign bus.m_valid = (count_q != '0);
    assign bus.m_len   = bus.m_valid ? head.len : '0;
    assign bus.m_ts    = bus.m_valid ? head.ts  : '0;
    assign bus.m_idx   = bus.m_valid ? head.idx : '0;
    assign bus.m_err   = bus.m_valid ? head.err : 1'b0;
    assign bus.s_ready = s_ready_q;
    assign pktcount    = pktcount_q;
    assign bytecount   = bytecount_q;
endmodule

// File: tb/tb_axis_packet_capture.sv
// Directed self-checking bench for axis_packet_capture (512-bit bus, 4-deep record FIFO).
module tb_axis_packet_capture;
    localparam int W = 512;
    localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        pause = 1'b0;
    logic [15:0] pktcount;
    logic [31:0] bytecount;
    logic [63:0] tb_cyc;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    axis_packet_capture_if #(.AXIS_WIDTH(W)) bus ();

    axis_packet_capture #(
        .AXIS_WIDTH(W), .META_DEPTH(4), .MAX_PKT_BYTES(65535)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pause(pause), .bus(bus),
        .pktcount(pktcount), .bytecount(bytecount)
    );

    always #5 clk = ~clk;

    // Reference cycle count: zero in reset, +1 on every edge after release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 64'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic string got_rec();
        return $sformatf("v=%0b len=%0d ts=%0d idx=%0d err=%0b",
                         bus.m_valid, bus.m_len, bus.m_ts, bus.m_idx, bus.m_err);
    endfunction

    // Holds one beat until it is accepted; ts returns the cycle count at the accept edge.
    task automatic send_beat(input logic [63:0] strb, input logic eop, output logic [63:0] ts);
        int n;
        bus.s_strb  = strb;
        bus.s_eop   = eop;
        bus.s_data  = {16{$urandom()}};
        bus.s_valid = 1'b1;
        n = 0;
        while (bus.s_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (bus.s_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", bus.s_ready, n);
        end
        ts = tb_cyc;
        step();
        bus.s_valid = 1'b0;
    endtask

    task automatic pop_record();
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.s_valid = 1'b0;
        bus.s_eop   = 1'b0;
        bus.s_strb  = '0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        pause       = 1'b0;
        rst_n       = 1'b0;
        repeat (3) step();
        n_checks++;
        if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: s_ready=%b m_valid=%b, required 0 0", bus.s_ready, bus.m_valid);
        end
        n_checks++;
        if ({bus.m_len, bus.m_ts, bus.m_idx, bus.m_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_record: got %s, required all zero", got_rec());
        end
        n_checks++;
        if (pktcount !== 16'd0 || bytecount !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counts: pktcount=%0d bytecount=%0d, required 0 0", pktcount, bytecount);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: s_ready=%b, required 1", bus.s_ready);
        end
    endtask

    task automatic test_single_beat();
        logic [63:0] t;
        int n;
        n = 0;
        while (tb_cyc != 64'd10 && n < 20) begin
            step();
            n++;
        end
        send_beat(64'h0000_000F_FFFF_FFFF, 1'b1, t);
        n_checks++;
        if ({bus.m_valid, bus.m_len, bus.m_ts, bus.m_idx, bus.m_err} !== {1'b1, 16'd36, 64'd10, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_record: got %s, required v=1 len=36 ts=10 idx=0 err=0", got_rec());
        end
        n_checks++;
        if (pktcount !== 16'd1 || bytecount !== 32'd36) begin
            n_fail++;
            $display("FAIL single_counts: pktcount=%0d bytecount=%0d, required 1 36", pktcount, bytecount);
        end
        pop_record();
        n_checks++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: m_valid=%b, required 0", bus.m_valid);
        end
    endtask

    task automatic test_multi_beat();
        logic [63:0] ts0, t;
        send_beat(ALL, 1'b0, ts0);
        send_beat(ALL, 1'b0, t);
        n_checks++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_early: m_valid=%b before eop, required 0", bus.m_valid);
        end
        send_beat(64'h3FF, 1'b1, t);
        n_checks++;
        if ({bus.m_valid, bus.m_len, bus.m_ts, bus.m_idx, bus.m_err} !== {1'b1, 16'd138, ts0, 16'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL multi_record: got %s, required v=1 len=138 ts=%0d idx=1 err=0", got_rec(), ts0);
        end
        n_checks++;
        if (pktcount !== 16'd2 || bytecount !== 32'd174) begin
            n_fail++;
            $display("FAIL multi_counts: pktcount=%0d bytecount=%0d, required 2 174", pktcount, bytecount);
        end
        pop_record();
    endtask

    task automatic test_strobe_errors();
        logic [63:0] ts0, t;
        send_beat(ALL, 1'b0, ts0);
        send_beat(64'hFFFF, 1'b0, t);
        send_beat(64'hFF, 1'b1, t);
        n_checks++;
        if ({bus.m_valid, bus.m_len, bus.m_ts, bus.m_idx, bus.m_err} !== {1'b1, 16'd88, ts0, 16'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL short_middle: got %s, required v=1 len=88 ts=%0d idx=2 err=1", got_rec(), ts0);
        end
        pop_record();
        send_beat(64'h5, 1'b1, ts0);
        n_checks++;
        if ({bus.m_valid, bus.m_len, bus.m_ts, bus.m_idx, bus.m_err} !== {1'b1, 16'd2, ts0, 16'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL holey_strb: got %s, required v=1 len=2 ts=%0d idx=3 err=1", got_rec(), ts0);
        end
        pop_record();
        send_beat(64'h0, 1'b1, ts0);
        n_checks++;
        if ({bus.m_valid, bus.m_len, bus.m_ts, bus.m_idx, bus.m_err} !== {1'b1, 16'd0, ts0, 16'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_strb: got %s, required v=1 len=0 ts=%0d idx=4 err=1", got_rec(), ts0);
        end
        pop_record();
        send_beat(64'hF, 1'b1, ts0);
        n_checks++;
        if ({bus.m_valid, bus.m_len, bus.m_ts, bus.m_idx, bus.m_err} !== {1'b1, 16'd4, ts0, 16'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL err_clears: got %s, required v=1 len=4 ts=%0d idx=5 err=0", got_rec(), ts0);
        end
        pop_record();
        n_checks++;
        if (pktcount !== 16'd6 || bytecount !== 32'd268) begin
            n_fail++;
            $display("FAIL strobe_counts: pktcount=%0d bytecount=%0d, required 6 268", pktcount, bytecount);
        end
    endtask

    task automatic test_length_limit();
        logic [63:0] ts0, t;
        // 1023 full beats + 63 bytes lands exactly on the 65535-byte limit.
        for (int i = 0; i < 1023; i++) begin
            send_beat(ALL, 1'b0, t);
            if (i == 0) ts0 = t;
        end
        send_beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, t);
        n_checks++;
        if ({bus.m_valid, bus.m_len, bus.m_ts, bus.m_idx, bus.m_err} !== {1'b1, 16'd65535, ts0, 16'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL len_at_limit: got %s, required v=1 len=65535 ts=%0d idx=6 err=0", got_rec(), ts0);
        end
        pop_record();
        // 1025 full beats = 65600 bytes, one beat past the limit.
        for (int i = 0; i < 1025; i++) begin
            send_beat(ALL, (i == 1024), t);
            if (i == 0) ts0 = t;
        end
        n_checks++;
        if ({bus.m_valid, bus.m_len, bus.m_ts, bus.m_idx, bus.m_err} !== {1'b1, 16'd65535, ts0, 16'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL len_saturate: got %s, required v=1 len=65535 ts=%0d idx=7 err=1", got_rec(), ts0);
        end
        pop_record();
        n_checks++;
        if (pktcount !== 16'd8 || bytecount !== 32'd131403) begin
            n_fail++;
            $display("FAIL length_counts: pktcount=%0d bytecount=%0d, required 8 131403", pktcount, bytecount);
        end
    endtask

    task automatic test_pause();
        logic [63:0] ts0, t;
        send_beat(ALL, 1'b0, ts0);
        send_beat(ALL, 1'b0, t);
        pause = 1'b1;
        send_beat(ALL, 1'b0, t);
        bus.s_strb  = ALL;
        bus.s_eop   = 1'b1;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (bus.s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_ready[%0d]: s_ready=%b, required 0", i, bus.s_ready);
            end
            step();
        end
        n_checks++;
        if (pktcount !== 16'd8 || bytecount !== 32'd131595) begin
            n_fail++;
            $display("FAIL pause_hold: pktcount=%0d bytecount=%0d, required 8 131595", pktcount, bytecount);
        end
        pause = 1'b0;
        send_beat(ALL, 1'b1, t);
        n_checks++;
        if ({bus.m_valid, bus.m_len, bus.m_ts, bus.m_idx, bus.m_err} !== {1'b1, 16'd256, ts0, 16'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL pause_record: got %s, required v=1 len=256 ts=%0d idx=8 err=0", got_rec(), ts0);
        end
        n_checks++;
        if (pktcount !== 16'd9 || bytecount !== 32'd131659) begin
            n_fail++;
            $display("FAIL pause_counts: pktcount=%0d bytecount=%0d, required 9 131659", pktcount, bytecount);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [63:0] t;
        send_beat(ALL, 1'b0, t);
        send_beat(ALL, 1'b0, t);
        bus.s_strb  = ALL;
        bus.s_eop   = 1'b0;
        bus.s_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.s_ready !== 1'b0 || {bus.m_valid, bus.m_len, bus.m_ts, bus.m_idx, bus.m_err} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: s_ready=%b %s, required all zero", bus.s_ready, got_rec());
        end
        n_checks++;
        if (pktcount !== 16'd0 || bytecount !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_counts: pktcount=%0d bytecount=%0d, required 0 0", pktcount, bytecount);
        end
        bus.s_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        send_beat(64'hF, 1'b1, t);
        n_checks++;
        if ({bus.m_valid, bus.m_len, bus.m_ts, bus.m_idx, bus.m_err} !== {1'b1, 16'd4, 64'd1, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL midrst_next: got %s, required v=1 len=4 ts=1 idx=0 err=0", got_rec());
        end
        pop_record();
        n_checks++;
        if (bus.m_valid !== 1'b0 || pktcount !== 16'd1) begin
            n_fail++;
            $display("FAIL midrst_single: m_valid=%b pktcount=%0d, required 0 1", bus.m_valid, pktcount);
        end
    endtask

    task automatic test_fifo_full();
        logic [63:0] t;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) send_beat(64'h1, 1'b1, t);
        n_checks++;
        if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_ready: s_ready=%b m_valid=%b, required 0 1", bus.s_ready, bus.m_valid);
        end
        bus.s_strb  = 64'h1;
        bus.s_eop   = 1'b1;
        bus.s_valid = 1'b1;
        repeat (3) step();
        n_checks++;
        if (pktcount !== 16'd4 || bus.s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_stall: pktcount=%0d s_ready=%b, required 4 0", pktcount, bus.s_ready);
        end
        n_checks++;
        if (bus.m_idx !== 16'd0) begin
            n_fail++;
            $display("FAIL full_head: m_idx=%0d, required 0", bus.m_idx);
        end
        pop_record();
        n_checks++;
        if (bus.s_ready !== 1'b1 || pktcount !== 16'd4) begin
            n_fail++;
            $display("FAIL full_release: s_ready=%b pktcount=%0d, required 1 4", bus.s_ready, pktcount);
        end
        step();
        bus.s_valid = 1'b0;
        n_checks++;
        if (pktcount !== 16'd5) begin
            n_fail++;
            $display("FAIL full_fifth: pktcount=%0d, required 5", pktcount);
        end
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (bus.m_valid !== 1'b1 || bus.m_idx !== 16'(i) || bus.m_len !== 16'd1) begin
                n_fail++;
                $display("FAIL full_order[%0d]: got %s, required v=1 len=1 idx=%0d", i, got_rec(), i);
            end
            pop_record();
        end
        n_checks++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drained: m_valid=%b, required 0", bus.m_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_strobe_errors();
        test_length_limit();
        test_pause();
        test_reset_mid_packet();
        test_fifo_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run still active at 1000000 time units, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
